// File: rtl/block_memory_retrieval.sv
// Read-side walker for the SSID hit store: HNM -> HCM -> HLM, then streams hit-info oldest-first.
// Optional RETRIEVAL_STATS_EN adds saturating query/hit counters.
module block_memory_retrieval #(
  parameter int unsigned SSIDBITS         = 12,
  parameter int unsigned COLINDEXBITS_HNM = 4,
  parameter int unsigned ROWINDEXBITS_HLM = 9,
  parameter int unsigned MAXHITNBITS      = 3,
  parameter int unsigned HITINFOBITS      = 8,
  localparam int unsigned NCOLS_HNM       = 2**COLINDEXBITS_HNM,
  localparam int unsigned MAXHITS         = 2**MAXHITNBITS - 1,
  localparam int unsigned ROWBITS         = HITINFOBITS * MAXHITS
) (
  input  logic                                 clock,
  input  logic                                 resetN,
  input  logic                                 clearMemory,
  input  logic                                 queryValid,
  output logic                                 queryReady,
  input  logic [SSIDBITS-1:0]                  querySSID,
  output logic [SSIDBITS-COLINDEXBITS_HNM-1:0] hnmAddr,
  input  logic [NCOLS_HNM-1:0]                 hnmData,
  output logic [SSIDBITS-1:0]                  hcmAddr,
  input  logic [ROWINDEXBITS_HLM+MAXHITNBITS-1:0] hcmData,
  output logic [ROWINDEXBITS_HLM-1:0]          hlmAddr,
  input  logic [ROWBITS-1:0]                   hlmData,
  output logic                                 outValid,
  input  logic                                 outReady,
  output logic [HITINFOBITS-1:0]               outHitInfo,
  output logic                                 outLast,
  output logic                                 outEmpty,
`ifdef RETRIEVAL_STATS_EN
  output logic [15:0]                          statQueries,
  output logic [15:0]                          statHits,
`endif
  output logic [SSIDBITS-1:0]                  outSSID
);

  typedef enum logic [2:0] {
    IDLE, HNM_ADDR, HNM_DATA, HCM_ADDR, HCM_DATA, HLM_ADDR, HLM_DATA, STREAM
  } stateType;

  stateType                    state;
  logic                        armed;
  logic [MAXHITNBITS-1:0]      hitCount;
  logic [MAXHITNBITS-1:0]      idx;
  logic [MAXHITNBITS-1:0]      nextIdx;
  logic [ROWBITS-1:0]          hitRow;
  logic                        hnmBit;
  logic [MAXHITNBITS-1:0]      hcmCount;
  logic [ROWINDEXBITS_HLM-1:0] hcmRowAddr;

  // armed keeps queryReady low until the first edge after reset release
  assign queryReady = armed && (state == IDLE) && !clearMemory;
  assign hnmBit     = hnmData[outSSID[COLINDEXBITS_HNM-1:0]];
  assign {hcmRowAddr, hcmCount} = hcmData;
  assign nextIdx    = idx + MAXHITNBITS'(1);

  // Newest hit lives in slot 0, so slot (count-1-idx) is the idx-th oldest word
  function automatic logic [HITINFOBITS-1:0] pickWord(input logic [ROWBITS-1:0] row,
                                                      input logic [MAXHITNBITS-1:0] slot);
    pickWord = '0;
    for (int k = 0; k < MAXHITS; k++)
      if (slot == MAXHITNBITS'(k)) pickWord = row[k*HITINFOBITS +: HITINFOBITS];
  endfunction

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      armed      <= 1'b0;
      outValid   <= 1'b0;
      outLast    <= 1'b0;
      outEmpty   <= 1'b0;
      outHitInfo <= '0;
      outSSID    <= '0;
      hnmAddr    <= '0;
      hcmAddr    <= '0;
      hlmAddr    <= '0;
      hitCount   <= '0;
      idx        <= '0;
      hitRow     <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (queryValid && queryReady) begin
            outSSID <= querySSID;
            hnmAddr <= querySSID[SSIDBITS-1:COLINDEXBITS_HNM];
            state   <= HNM_ADDR;
          end
        end
        HNM_ADDR: state <= HNM_DATA;
        HNM_DATA: begin
          if (hnmBit) begin
            hcmAddr <= outSSID;
            state   <= HCM_ADDR;
          end else begin
            outValid   <= 1'b1;
            outEmpty   <= 1'b1;
            outLast    <= 1'b1;
            outHitInfo <= '0;
            state      <= STREAM;
          end
        end
        HCM_ADDR: state <= HCM_DATA;
        HCM_DATA: begin
          hitCount <= hcmCount;
          hlmAddr  <= hcmRowAddr;
          if (hcmCount == '0) begin
            outValid   <= 1'b1;
            outEmpty   <= 1'b1;
            outLast    <= 1'b1;
            outHitInfo <= '0;
            state      <= STREAM;
          end else begin
            state <= HLM_ADDR;
          end
        end
        HLM_ADDR: state <= HLM_DATA;
        HLM_DATA: begin
          hitRow     <= hlmData;
          idx        <= '0;
          outValid   <= 1'b1;
          outEmpty   <= 1'b0;
          outHitInfo <= pickWord(hlmData, hitCount - MAXHITNBITS'(1));
          outLast    <= (hitCount == MAXHITNBITS'(1));
          state      <= STREAM;
        end
        STREAM: begin
          if (outReady) begin
            if (outLast) begin
              outValid   <= 1'b0;
              outLast    <= 1'b0;
              outEmpty   <= 1'b0;
              outHitInfo <= '0;
              state      <= IDLE;
            end else begin
              idx        <= nextIdx;
              outHitInfo <= pickWord(hitRow, hitCount - MAXHITNBITS'(1) - nextIdx);
              outLast    <= (nextIdx == hitCount - MAXHITNBITS'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RETRIEVAL_STATS_EN
  // Saturating activity counters, wiped whenever storage is cleared
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      statQueries <= '0;
      statHits    <= '0;
    end else if (clearMemory) begin
      statQueries <= '0;
      statHits    <= '0;
    end else begin
      if (queryValid && queryReady && statQueries != 16'hFFFF)
        statQueries <= statQueries + 16'd1;
      if (state == STREAM && outValid && outReady && !outEmpty && statHits != 16'hFFFF)
        statHits <= statHits + 16'd1;
    end
  end
`endif

endmodule
